// File: rtl/fpga_strap_pkg.sv
// Strap overlay shared types: boot modes, sampler states
// and the reserved-strap fold.
package fpga_strap_pkg;

  typedef enum logic [1:0] {
    ModeNormal    = 2'b00,
    ModeJtag      = 2'b01,
    ModeBootstrap = 2'b10,
    ModeReserved  = 2'b11
  } strap_mode_e;

  typedef enum logic {
    StSample = 1'b0,
    StLocked = 1'b1
  } strap_state_e;

  function automatic strap_mode_e map_mode(
    input logic [1:0] s
  );
    strap_mode_e m;
    m = strap_mode_e'(s);
    if (m == ModeReserved) m = ModeNormal;
    return m;
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for asynchronous pad inputs.
// Both stages reset to ResetValue.
module prim_flop_2sync #(
  parameter int unsigned Width = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fpga_strap_overlay.sv
// Samples boot straps after reset, debounces and latches a mode,
// and overlays the JTAG TAP onto DIO pads when in Jtag mode.
module fpga_strap_overlay
  import fpga_strap_pkg::*;
#(
  parameter int unsigned NDioPads       = 15,
  parameter int unsigned DebounceCycles = 16,
  parameter int unsigned Strap0Idx      = 11,
  parameter int unsigned Strap1Idx      = 12,
  parameter int unsigned TckIdx         = 13,
  parameter int unsigned TmsIdx         = 14,
  parameter int unsigned TdiIdx         = 11,
  parameter int unsigned TdoIdx         = 12
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                resample_i,
  input  logic [NDioPads-1:0] dio_in_padring_i,
  output logic [NDioPads-1:0] dio_out_padring_o,
  output logic [NDioPads-1:0] dio_oe_padring_o,
  input  logic [NDioPads-1:0] dio_out_core_i,
  input  logic [NDioPads-1:0] dio_oe_core_i,
  output logic [NDioPads-1:0] dio_in_core_o,
  output logic                jtag_tck_o,
  output logic                jtag_tms_o,
  output logic                jtag_tdi_o,
  output logic                jtag_trst_no,
  input  logic                jtag_tdo_i,
  output logic [1:0]          mode_o,
  output logic                mode_valid_o,
  output logic                bootstrap_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax =
    CntW'(DebounceCycles - 1);

  if (DebounceCycles < 2) begin : g_bad_debounce
    $error("DebounceCycles must be at least 2");
  end

  if (Strap0Idx >= NDioPads || Strap1Idx >= NDioPads ||
      TckIdx >= NDioPads || TmsIdx >= NDioPads ||
      TdiIdx >= NDioPads || TdoIdx >= NDioPads) begin : g_bad_idx
    $error("pad index out of range");
  end

  if (TckIdx == TmsIdx || TckIdx == TdiIdx ||
      TckIdx == TdoIdx || TmsIdx == TdiIdx ||
      TmsIdx == TdoIdx || TdiIdx == TdoIdx) begin : g_bad_jtag
    $error("JTAG pad indices must be distinct");
  end

  if (Strap0Idx == Strap1Idx) begin : g_bad_strap
    $error("strap pad indices must be distinct");
  end

  logic [1:0]      strap_raw;
  logic [1:0]      strap_s;
  strap_state_e    state_q, state_d;
  logic [1:0]      strap_q, strap_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  strap_mode_e     mode_q, mode_d;
  logic            locked;
  logic            jtag_on;

  assign strap_raw = {dio_in_padring_i[Strap1Idx],
                      dio_in_padring_i[Strap0Idx]};

  prim_flop_2sync #(
    .Width      (2),
    .ResetValue (2'b00)
  ) u_strap_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (strap_raw),
    .q_o    (strap_s)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StSample;
      strap_q <= 2'b00;
      cnt_q   <= '0;
      mode_q  <= ModeNormal;
    end else begin
      state_q <= state_d;
      strap_q <= strap_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    strap_d = strap_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      StSample: begin
        if (strap_s != strap_q) begin
          strap_d = strap_s;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StLocked;
          mode_d  = map_mode(strap_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLocked: begin
        // strap_q is kept so an unchanged strap relocks quickly
        if (resample_i) begin
          state_d = StSample;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign locked       = (state_q == StLocked);
  assign jtag_on      = locked && (mode_q == ModeJtag);
  assign mode_o       = mode_q;
  assign mode_valid_o = locked;
  assign bootstrap_o  = locked && (mode_q == ModeBootstrap);

  always_comb begin
    dio_out_padring_o = dio_out_core_i;
    dio_oe_padring_o  = dio_oe_core_i;
    dio_in_core_o     = dio_in_padring_i;
    jtag_tck_o        = 1'b0;
    jtag_tms_o        = 1'b0;
    jtag_tdi_o        = 1'b0;
    jtag_trst_no      = 1'b0;
    if (!locked) begin
      dio_oe_padring_o[Strap0Idx] = 1'b0;
      dio_oe_padring_o[Strap1Idx] = 1'b0;
    end
    if (jtag_on) begin
      jtag_trst_no = 1'b1;
      jtag_tck_o   = dio_in_padring_i[TckIdx];
      jtag_tms_o   = dio_in_padring_i[TmsIdx];
      jtag_tdi_o   = dio_in_padring_i[TdiIdx];
      dio_out_padring_o[TckIdx] = 1'b0;
      dio_out_padring_o[TmsIdx] = 1'b0;
      dio_out_padring_o[TdiIdx] = 1'b0;
      dio_oe_padring_o[TckIdx]  = 1'b0;
      dio_oe_padring_o[TmsIdx]  = 1'b0;
      dio_oe_padring_o[TdiIdx]  = 1'b0;
      dio_in_core_o[TckIdx]     = 1'b0;
      dio_in_core_o[TmsIdx]     = 1'b0;
      dio_in_core_o[TdiIdx]     = 1'b0;
      dio_out_padring_o[TdoIdx] = jtag_tdo_i;
      dio_oe_padring_o[TdoIdx]  = 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_strap_overlay.sv
// Directed bench for fpga_strap_overlay: lock latency, JTAG
// overlay, resample, async reset and reserved strap handling.
module tb_fpga_strap_overlay;

  logic        clk;
  logic        rst_n;
  logic        resample;
  logic [14:0] pad_in;
  logic [14:0] pad_out;
  logic [14:0] pad_oe;
  logic [14:0] core_out;
  logic [14:0] core_oe;
  logic [14:0] core_in;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        trst_n;
  logic        tdo;
  logic [1:0]  mode;
  logic        mode_valid;
  logic        boot;

  int n_checks = 0;
  int n_pass   = 0;

  fpga_strap_overlay u_dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .resample_i        (resample),
    .dio_in_padring_i  (pad_in),
    .dio_out_padring_o (pad_out),
    .dio_oe_padring_o  (pad_oe),
    .dio_out_core_i    (core_out),
    .dio_oe_core_i     (core_oe),
    .dio_in_core_o     (core_in),
    .jtag_tck_o        (tck),
    .jtag_tms_o        (tms),
    .jtag_tdi_o        (tdi),
    .jtag_trst_no      (trst_n),
    .jtag_tdo_i        (tdo),
    .mode_o            (mode),
    .mode_valid_o      (mode_valid),
    .bootstrap_o       (boot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_strap(input logic [1:0] s);
    pad_in[11] = s[0];
    pad_in[12] = s[1];
  endtask

  task automatic do_reset(input logic [1:0] s);
    rst_n = 1'b0;
    set_strap(s);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    resample = 1'b0;
    tdo      = 1'b0;
    core_out = 15'h2AAA;
    core_oe  = 15'h7FFF;
    pad_in   = 15'h6000;
    set_strap(2'b01);
    repeat (2) @(negedge clk);

    check("rst_valid", 32'(mode_valid), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_boot", 32'(boot), 32'd0);
    check("rst_trst", 32'(trst_n), 32'd0);
    check("rst_tck", 32'(tck), 32'd0);
    check("rst_tms", 32'(tms), 32'd0);
    check("rst_tdi", 32'(tdi), 32'd0);
    check("rst_oe", 32'(pad_oe), 32'h67FF);
    check("rst_out", 32'(pad_out), 32'h2AAA);
    check("rst_in", 32'(core_in), 32'(pad_in));

    // straps 01 from reset: lock after edge 19
    pad_in[13] = 1'b0;
    rst_n = 1'b1;
    tick(18);
    check("j_pre", 32'(mode_valid), 32'd0);
    tick(1);
    check("j_valid", 32'(mode_valid), 32'd1);
    check("j_mode", 32'(mode), 32'd1);
    check("j_trst", 32'(trst_n), 32'd1);
    check("j_tms", 32'(tms), 32'd1);
    check("j_tdi", 32'(tdi), 32'd1);
    tdo = 1'b1;
    #1;
    check("j_out", 32'(pad_out), 32'h12AA);
    check("j_oe", 32'(pad_oe), 32'h17FF);
    check("j_in", 32'(core_in), 32'(pad_in & 15'h17FF));
    for (int i = 0; i < 4; i++) begin
      pad_in[13] = ~pad_in[13];
      #1;
      check("j_tck", 32'(tck), 32'(pad_in[13]));
      check("j_in13", 32'(core_in[13]), 32'd0);
      tick(5);
    end

    // straps change while locked: mode frozen
    set_strap(2'b00);
    tick(30);
    check("frz_mode", 32'(mode), 32'd1);
    check("frz_valid", 32'(mode_valid), 32'd1);
    tdo = 1'b0;
    #1;
    check("frz_tdo", 32'(pad_out), 32'h02AA);

    // resample with strap_s != strap_q: relock at N+17
    @(negedge clk);
    pad_in[13] = 1'b1;
    resample = 1'b1;
    tick(1);
    resample = 1'b0;
    check("rs_valid", 32'(mode_valid), 32'd0);
    check("rs_trst", 32'(trst_n), 32'd0);
    check("rs_tck", 32'(tck), 32'd0);
    check("rs_oe", 32'(pad_oe), 32'h67FF);
    tick(16);
    check("rs_pre", 32'(mode_valid), 32'd0);
    tick(1);
    check("rs_lock", 32'(mode_valid), 32'd1);
    check("rs_mode", 32'(mode), 32'd0);
    check("rs_out", 32'(pad_out), 32'h2AAA);
    check("rs_oe2", 32'(pad_oe), 32'h7FFF);
    check("rs_in", 32'(core_in), 32'(pad_in));

    // toggling 00/10 every 5 cycles never locks
    do_reset(2'b00);
    for (int i = 0; i < 8; i++) begin
      set_strap((i % 2 == 0) ? 2'b10 : 2'b00);
      for (int k = 0; k < 5; k++) begin
        tick(1);
        check("tg_nolock", 32'(mode_valid), 32'd0);
      end
    end
    set_strap(2'b10);
    tick(18);
    check("tg_pre", 32'(mode_valid), 32'd0);
    tick(1);
    check("tg_lock", 32'(mode_valid), 32'd1);
    check("tg_mode", 32'(mode), 32'd2);
    check("tg_boot", 32'(boot), 32'd1);

    // async reset mid-count (cnt = 9), then full latency
    do_reset(2'b10);
    tick(12);
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(mode_valid), 32'd0);
    check("ar_mode", 32'(mode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(18);
    check("ar_pre", 32'(mode_valid), 32'd0);
    tick(1);
    check("ar_lock", 32'(mode_valid), 32'd1);
    check("ar_boot", 32'(boot), 32'd1);
    check("ar_mode2", 32'(mode), 32'd2);
    rst_n = 1'b0;
    #1;
    check("arl_valid", 32'(mode_valid), 32'd0);
    check("arl_boot", 32'(boot), 32'd0);
    check("arl_mode", 32'(mode), 32'd0);

    // reserved strap 11 maps to Normal
    pad_in[13] = 1'b1;
    do_reset(2'b11);
    tick(18);
    check("rv_pre", 32'(mode_valid), 32'd0);
    tick(1);
    check("rv_valid", 32'(mode_valid), 32'd1);
    check("rv_mode", 32'(mode), 32'd0);
    check("rv_boot", 32'(boot), 32'd0);
    check("rv_trst", 32'(trst_n), 32'd0);
    check("rv_tck", 32'(tck), 32'd0);
    check("rv_tdi", 32'(tdi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
